// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: row drive, 2-flop bit-line sync, whole-matrix debounce, one key event per press.
// Optional auto-repeat of a held key is built only when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] o_word_lines,
    input  logic [3:0] i_bit_lines,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_held
);
    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_LOCKED} state_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    function automatic logic [3:0] key_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    logic [3:0]       r_sync_p0, r_sync_p1;
    logic [DIV_W-1:0] r_dwell;
    logic [1:0]       r_row;
    logic [3:0]       r_word_lines;
    logic [11:0]      r_snap;
    logic [15:0]      r_prev, r_stable;
    logic [3:0]       r_stable_cnt;
    state_t           r_state, w_state_next;
    logic [3:0]       r_key_code, w_key_code_next;
    logic             r_key_valid, w_key_valid_next;

    logic        w_sample, w_scan_done;
    logic [1:0]  w_row_next;
    logic [15:0] w_full_snap;
    logic [3:0]  w_cnt_next;
    logic [4:0]  w_pop;
    logic        w_single;

    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_scan_done = w_sample && (r_row == 2'd3);
    assign w_row_next  = w_sample ? r_row + 2'd1 : r_row;
    // Row 3 is never stored: it completes the snapshot straight from the synchronizer.
    assign w_full_snap = {r_sync_p1, r_snap};
    assign w_cnt_next  = (w_full_snap == r_prev) ? sat_inc4(r_stable_cnt) : 4'd1;
    assign w_pop       = 5'($countones(r_stable));
    assign w_single    = (w_pop == 5'd1);

    // Stage p0/p1: bit-line synchronizer, row sequencing and scan debounce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0    <= '0;
            r_sync_p1    <= '0;
            r_dwell      <= '0;
            r_row        <= '0;
            r_word_lines <= 4'b0001;
            r_snap       <= '0;
            r_prev       <= '0;
            r_stable     <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_sync_p0    <= i_bit_lines;
            r_sync_p1    <= r_sync_p0;
            r_dwell      <= w_sample ? '0 : r_dwell + DIV_W'(1);
            r_row        <= w_row_next;
            r_word_lines <= 4'b0001 << w_row_next;
            if (w_sample) begin
                case (r_row)
                    2'd0:    r_snap[3:0]  <= r_sync_p1;
                    2'd1:    r_snap[7:4]  <= r_sync_p1;
                    2'd2:    r_snap[11:8] <= r_sync_p1;
                    default: ;
                endcase
            end
            if (w_scan_done) begin
                r_prev       <= w_full_snap;
                r_stable_cnt <= w_cnt_next;
                if (w_cnt_next >= DEB_TARGET) r_stable <= w_full_snap;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_SCANS) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

    logic             r_scan_done_p1;
    logic [REP_W-1:0] r_rep_cnt;
    logic             w_repeat_fire;

    // Counted one cycle late so repeats line up with the stable-state update.
    assign w_repeat_fire = r_scan_done_p1 && (r_rep_cnt == REP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_done_p1 <= 1'b0;
        end else begin
            r_scan_done_p1 <= w_scan_done;
        end
        if (rst || r_state != S_PRESSED || w_state_next != S_PRESSED) begin
            r_rep_cnt <= '0;
        end else if (r_scan_done_p1) begin
            r_rep_cnt <= w_repeat_fire ? '0 : r_rep_cnt + REP_W'(1);
        end
    end
`else
    logic w_repeat_fire;
    logic w_unused_repeat;
    assign w_repeat_fire   = 1'b0;
    assign w_unused_repeat = (REPEAT_SCANS > 0);
`endif

    always_comb begin
        w_state_next     = r_state;
        w_key_valid_next = 1'b0;
        w_key_code_next  = r_key_code;
        case (r_state)
            S_IDLE: begin
                if (w_single) begin
                    w_state_next     = S_PRESSED;
                    w_key_valid_next = 1'b1;
                    w_key_code_next  = key_index(r_stable);
                end else if (w_pop >= 5'd2) begin
                    w_state_next = S_LOCKED;
                end
            end
            S_PRESSED: begin
                if (w_pop == 5'd0) begin
                    w_state_next = S_IDLE;
                end else if (!w_single || r_stable != (16'd1 << r_key_code)) begin
                    w_state_next = S_LOCKED;
                end else if (w_repeat_fire) begin
                    w_key_valid_next = 1'b1;
                end
            end
            S_LOCKED: begin
                if (w_pop == 5'd0) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stage p2: key event registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_key_code  <= w_key_code_next;
            r_key_valid <= w_key_valid_next;
        end
    end

    assign o_word_lines = r_word_lines;
    assign o_key_code   = r_key_code;
    assign o_key_valid  = r_key_valid;
    assign o_key_held   = (r_state == S_PRESSED);
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: switch-matrix model plus a scan-level reference of debounce and key events.
// Expects REPEAT_SCANS=4 auto-repeat behaviour when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_matrix_scanner;
    localparam int SCAN_CYC = 16;
    localparam int DEB      = 3;
    localparam int REP      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  word, bits, code;
    logic        valid, held;
    logic [15:0] keys = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    int      g_pulses = 0;
    int      g_code   = 0;
    logic    g_prev_valid = 1'b0;
    longint  g_cycle = 0;
    longint  g_pulse_t[$];

    logic [15:0] m_prev, m_stable;
    int          m_cnt, m_mode, m_code, m_rep, m_exp_pulses;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DEB), .REPEAT_SCANS(REP)) dut (
        .clk(clk), .rst(rst), .o_word_lines(word), .i_bit_lines(bits),
        .o_key_code(code), .o_key_valid(valid), .o_key_held(held)
    );

    // Pressed switches connect the driven row to their column.
    always_comb begin
        bits = '0;
        for (int r = 0; r < 4; r++) begin
            if (word[r]) bits = bits | keys[r*4 +: 4];
        end
    end

    task automatic tick();
        @(negedge clk);
        g_cycle++;
        if (valid === 1'b1) begin
            tests_run++;
            if (g_prev_valid) begin
                tests_failed++;
                $display("FAIL valid_double: valid high two cycles running at cycle %0d", g_cycle);
            end
            g_pulses++;
            g_code = int'(code);
            g_pulse_t.push_back(g_cycle);
        end
        g_prev_valid = (valid === 1'b1);
    endtask

    task automatic model_reset();
        m_prev = '0; m_stable = '0; m_cnt = 0; m_mode = 0; m_code = 0; m_rep = 0; m_exp_pulses = 0;
    endtask

    // One full scan of the reference: mode 0 idle, 1 single key held, 2 locked.
    task automatic model_step(input logic [15:0] snap);
        int pop;
        int idx;
        m_exp_pulses = 0;
        if (snap == m_prev) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else m_cnt = 1;
        m_prev = snap;
        if (m_cnt >= DEB) m_stable = snap;
        pop = 0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_stable[i]) begin
                pop++;
                idx = i;
            end
        end
        case (m_mode)
            0: begin
                if (pop == 1) begin
                    m_mode = 1; m_code = idx; m_exp_pulses = 1; m_rep = 0;
                end else if (pop >= 2) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (pop == 0) m_mode = 0;
                else if (pop >= 2 || idx != m_code) m_mode = 2;
                else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_rep++;
                    if (m_rep == REP) begin
                        m_exp_pulses = 1;
                        m_rep = 0;
                    end
`endif
                end
            end
            default: if (pop == 0) m_mode = 0;
        endcase
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_valid: got %b, want 0", valid);
            end
        end
        tests_run++;
        if (word !== 4'b0001 || held !== 1'b0 || code !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_state: word=%b held=%b code=%0d, want 0001/0/0", word, held, code);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // Called at the first cycle of a scan; keys stay constant for the whole scan.
    task automatic do_scan(input logic [15:0] k);
        int start;
        int n;
        keys = k;
        start = g_pulses;
        repeat (SCAN_CYC) tick();
        n = g_pulses - start;
        tests_run++;
        if (n != m_exp_pulses) begin
            tests_failed++;
            $display("FAIL scan_pulses: got %0d pulses, want %0d (keys %h)", n, m_exp_pulses, k);
        end
        if (m_exp_pulses > 0) begin
            tests_run++;
            if (g_code != m_code) begin
                tests_failed++;
                $display("FAIL scan_code: got %0d, want %0d", g_code, m_code);
            end
        end
        tests_run++;
        if (held !== (m_mode == 1)) begin
            tests_failed++;
            $display("FAIL scan_held: got %b, want %b", held, (m_mode == 1));
        end
        model_step(k);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_word;
        do_reset(2);
        for (int i = 1; i <= SCAN_CYC; i++) begin
            tick();
            exp_word = 4'b0001 << ((i % SCAN_CYC) / 4);
            tests_run++;
            if (word !== exp_word) begin
                tests_failed++;
                $display("FAIL row_cycle: cycle %0d got %b, want %b", i, word, exp_word);
            end
        end
    endtask

    task automatic test_single_press();
        int     p0;
        longint t0;
        do_reset(1);
        g_pulse_t.delete();
        t0 = g_cycle;
        p0 = g_pulses;
        for (int s = 0; s < 6; s++) do_scan(16'd1 << 9);
        check_int("press9_count", g_pulses - p0, 1);
        check_int("press9_code", g_code, 9);
        check_int("press9_held", int'(held), 1);
        if (g_pulse_t.size() > 0) check_int("press9_latency_ok", int'(g_pulse_t[0] - t0 <= 68), 1);
        p0 = g_pulses;
        for (int s = 0; s < 4; s++) do_scan(16'd0);
        check_int("release9_held", int'(held), 0);
        for (int s = 0; s < 2; s++) do_scan(16'd0);
        check_int("release9_count", g_pulses - p0, 0);
    endtask

    task automatic test_bounce();
        int p0;
        do_reset(1);
        p0 = g_pulses;
        for (int c = 0; c < 60; c++) begin
            keys = ((c / 10) % 2 == 0) ? (16'd1 << 5) : 16'd0;
            tick();
        end
        check_int("bounce_quiet", g_pulses - p0, 0);
        keys = 16'd1 << 5;
        repeat (132) tick();
        check_int("bounce_count", g_pulses - p0, 1);
        check_int("bounce_code", g_code, 5);
        check_int("bounce_held", int'(held), 1);
    endtask

    task automatic test_multi_key();
        int p0;
        do_reset(1);
        p0 = g_pulses;
        for (int s = 0; s < 6; s++) do_scan((16'd1 << 3) | (16'd1 << 12));
        check_int("multi_both", g_pulses - p0, 0);
        check_int("multi_held", int'(held), 0);
        p0 = g_pulses;
        for (int s = 0; s < 6; s++) do_scan(16'd1 << 3);
        check_int("multi_drop12", g_pulses - p0, 0);
        p0 = g_pulses;
        for (int s = 0; s < 6; s++) do_scan(16'd0);
        check_int("multi_release", g_pulses - p0, 0);
        p0 = g_pulses;
        for (int s = 0; s < 6; s++) do_scan(16'd1 << 7);
        check_int("multi_then7_count", g_pulses - p0, 1);
        check_int("multi_then7_code", g_code, 7);
    endtask

    task automatic test_reset_mid();
        int     p0;
        longint t0;
        do_reset(1);
        p0 = g_pulses;
        do_scan(16'd1);
        do_scan(16'd1);
        repeat (8) tick();
        do_reset(1);
        check_int("midreset_quiet", g_pulses - p0, 0);
        g_pulse_t.delete();
        t0 = g_cycle;
        for (int s = 0; s < 5; s++) do_scan(16'd1);
        check_int("midreset_count", g_pulses - p0, 1);
        check_int("midreset_code", g_code, 0);
        if (g_pulse_t.size() > 0) begin
            check_int("midreset_after3scans", int'(g_pulse_t[0] - t0 >= 48 && g_pulse_t[0] - t0 <= 52), 1);
        end
    endtask

    task automatic test_repeat();
        int p0;
        do_reset(1);
        keys = '0;
        g_pulse_t.delete();
        p0 = g_pulses;
        for (int s = 0; s < 12; s++) do_scan(16'd1 << 15);
        check_int("repeat_code", g_code, 15);
`ifdef KEYPAD_AUTOREPEAT_EN
        check_int("repeat_count", g_pulses - p0, 3);
        for (int i = 1; i < g_pulse_t.size(); i++) begin
            check_int("repeat_interval", int'(g_pulse_t[i] - g_pulse_t[i-1]), 64);
        end
`else
        check_int("repeat_count", g_pulses - p0, 1);
`endif
        for (int s = 0; s < 5; s++) do_scan(16'd0);
    endtask

    task automatic test_random();
        logic [15:0] k;
        int          kind;
        int          hold;
        do_reset(1);
        for (int seg = 0; seg < 30; seg++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       k = 16'd0;
                3:       k = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
                default: k = 16'd1 << $urandom_range(0, 15);
            endcase
            hold = $urandom_range(1, 5);
            for (int s = 0; s < hold; s++) do_scan(k);
        end
        for (int s = 0; s < 5; s++) do_scan(16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
